// File: rtl/fir_pkg.sv
// Shared widths, coefficient table and sample/accumulator types for the eight-tap FIR.
// Output clamping instead of wrap is selected by defining FIR_SATURATE_EN.
package fir_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned COEF_W = 16;
  localparam int unsigned TAPS   = 8;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  // Room for TAPS full-precision products without intermediate overflow.
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam coef_t COEF [TAPS] = '{
    coef_t'(1), coef_t'(2), coef_t'(3), coef_t'(4),
    coef_t'(4), coef_t'(3), coef_t'(2), coef_t'(1)
  };

endpackage

// File: rtl/fir_out_sat.sv
// Combinational output stage: arithmetic shift, then narrow the accumulator to a sample.
// FIR_SATURATE_EN defined clamps to the sample range; otherwise the low bits wrap.
module fir_out_sat #(
  parameter int unsigned DATA_W = fir_pkg::DATA_W,
  parameter int unsigned ACC_W  = fir_pkg::ACC_W,
  parameter int unsigned SHIFT  = 0
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_sample
);

  logic signed [ACC_W-1:0] w_shifted;

  assign w_shifted = i_acc >>> SHIFT;

`ifdef FIR_SATURATE_EN
  logic [ACC_W-DATA_W:0] w_hi;
  logic                  w_in_range;

  // In range exactly when every bit above the sample's sign bit copies it.
  assign w_hi       = w_shifted[ACC_W-1:DATA_W-1];
  assign w_in_range = (&w_hi) | ~(|w_hi);

  always_comb begin
    o_sample = w_shifted[DATA_W-1:0];
    if (!w_in_range) begin
      if (w_shifted[ACC_W-1]) begin
        o_sample = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        o_sample = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_shifted[ACC_W-1:DATA_W];
  assign o_sample    = w_shifted[DATA_W-1:0];
`endif

endmodule

// File: rtl/direct_fir_filter.sv
// Direct-form FIR: delay line, full-precision multiply-accumulate, registered output.
// Define FIR_SATURATE_EN to clamp the output instead of wrapping on overflow.
module direct_fir_filter #(
  parameter int unsigned DATA_W = fir_pkg::DATA_W,
  parameter int unsigned COEF_W = fir_pkg::COEF_W,
  parameter int unsigned TAPS   = fir_pkg::TAPS,
  parameter int unsigned SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y_out
);

  import fir_pkg::*;

  localparam int unsigned PW = DATA_W + COEF_W;
  localparam int unsigned AW = PW + $clog2(TAPS);

  logic signed [DATA_W-1:0] r_dly [TAPS-1];
  logic signed [DATA_W-1:0] r_y;
  logic signed [DATA_W-1:0] w_taps [TAPS];
  logic signed [PW-1:0]     w_prod [TAPS];
  logic signed [AW-1:0]     w_acc;
  logic signed [DATA_W-1:0] w_y;

  // Tap 0 is the live input so the new sample reaches y_out after one edge.
  always_comb begin
    w_taps[0] = x_in;
    for (int k = 1; k < TAPS; k++) begin
      w_taps[k] = r_dly[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = PW'(w_taps[k]) * PW'(COEF[k]);
    end
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_acc = w_acc + AW'(w_prod[k]);
    end
  end

  fir_out_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (AW),
    .SHIFT  (SHIFT)
  ) u_out_sat (
    .i_acc    (w_acc),
    .o_sample (w_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        r_dly[k] <= '0;
      end
      r_y <= '0;
    end else begin
      r_dly[0] <= x_in;
      for (int k = 1; k < TAPS - 1; k++) begin
        r_dly[k] <= r_dly[k-1];
      end
      r_y <= w_y;
    end
  end

  assign y_out = r_y;

endmodule

// File: tb/tb_direct_fir_filter.sv
// Self-checking bench for direct_fir_filter: sample-history model checked every cycle
// plus literal vectors for reset, impulse, ramp, DC, overflow and mid-stream reset.
module tb_direct_fir_filter;

  logic               clk;
  logic               reset;
  logic signed [31:0] x_in;
  logic signed [31:0] y_out;

  int n_checks;
  int n_errors;

  longint hist [8];
  longint h [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  logic signed [31:0] m_y;

  direct_fir_filter #(
    .SHIFT (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic signed [31:0] narrow(input longint v);
    longint lo;
    longint hi;
    lo = -(64'sd1 <<< 31);
    hi = (64'sd1 <<< 31) - 1;
`ifdef FIR_SATURATE_EN
    if (v > hi) v = hi;
    if (v < lo) v = lo;
`endif
    return v[31:0];
  endfunction

  // y(n) = sum h[k] * x(n-k) over the retained history, newest sample first.
  task automatic model_edge(input logic signed [31:0] x, input logic rst_n);
    longint acc;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) hist[k] = 0;
      m_y = '0;
    end else begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = longint'(x);
      acc = 0;
      for (int k = 0; k < 8; k++) acc += h[k] * hist[k];
      m_y = narrow(acc);
    end
  endtask

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: drive, clock the model alongside the DUT, compare 1 ns after the edge.
  task automatic step(input logic signed [31:0] x, input logic rst_n);
    x_in  = x;
    reset = rst_n;
    @(posedge clk);
    model_edge(x, rst_n);
    #1;
    check("model", y_out, m_y);
  endtask

  logic signed [31:0] imp_exp [8] = '{100, 200, 300, 400, 400, 300, 200, 100};
  logic signed [31:0] ramp_exp [13] = '{100, 400, 1000, 2000, 3400, 4500, 5100, 5000,
                                        4000, 2600, 1400, 500, 0};
  logic signed [31:0] dc_exp [8] = '{-1000, -3000, -6000, -10000, -14000, -17000,
                                     -19000, -20000};
  logic signed [31:0] ramp_in [5] = '{100, 200, 300, 400, 500};

  initial begin
    n_checks = 0;
    n_errors = 0;
    x_in     = '0;
    reset    = 1'b0;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    m_y = '0;
    #2;

    // Reset held with a non-zero input.
    for (int i = 0; i < 10; i++) begin
      step(32'sd100, 1'b0);
      check("reset_hold", y_out, 32'sd0);
    end
    for (int i = 0; i < 3; i++) begin
      step(32'sd0, 1'b1);
      check("release_zero", y_out, 32'sd0);
    end

    // Impulse.
    step(32'sd100, 1'b1);
    check("impulse", y_out, imp_exp[0]);
    for (int i = 1; i < 8; i++) begin
      step(32'sd0, 1'b1);
      check("impulse", y_out, imp_exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      step(32'sd0, 1'b1);
      check("impulse_tail", y_out, 32'sd0);
    end

    // Ramp then zeros.
    for (int i = 0; i < 13; i++) begin
      step((i < 5) ? ramp_in[i] : 32'sd0, 1'b1);
      check("ramp", y_out, ramp_exp[i]);
    end

    // DC at -1000.
    for (int i = 0; i < 12; i++) begin
      step(-32'sd1000, 1'b1);
      check("dc", y_out, dc_exp[(i < 8) ? i : 7]);
    end
    for (int i = 0; i < 8; i++) step(32'sd0, 1'b1);

    // Overflow with full-scale positive input.
    for (int i = 0; i < 10; i++) step(32'sh7FFF_FFFF, 1'b1);
`ifdef FIR_SATURATE_EN
    check("overflow", y_out, 32'sh7FFF_FFFF);
`else
    check("overflow", y_out, 32'shFFFF_FFEC);
`endif
    for (int i = 0; i < 8; i++) step(32'sd0, 1'b1);
    check("overflow_flush", y_out, 32'sd0);

    // Reset mid-ramp, then an impulse must match a fresh start.
    for (int i = 0; i < 3; i++) step(ramp_in[i], 1'b1);
    check("pre_reset", y_out, 32'sd1000);
    step(32'sd500, 1'b0);
    check("mid_reset", y_out, 32'sd0);
    step(32'sd100, 1'b1);
    check("post_reset_imp", y_out, imp_exp[0]);
    for (int i = 1; i < 8; i++) begin
      step(32'sd0, 1'b1);
      check("post_reset_imp", y_out, imp_exp[i]);
    end
    step(32'sd0, 1'b1);
    check("post_reset_tail", y_out, 32'sd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/direct_fir_filter.md
# direct_fir_filter

Eight-tap direct-form FIR filter on a 32-bit signed sample stream, one new sample accepted every clock. It is the datapath core of the filtering project. A parent block feeds it raw samples, and it returns the filtered result through a single output register. It has no handshake: the filter is always running and treats every clock edge as a valid sample.

## Interface
- `DATA_W`, default 32: input/output sample width, signed two's complement.
- `COEF_W`, default 16: coefficient width, signed.
- `TAPS`, default 8: number of taps; the coefficient table in the package must match it.
- `SHIFT`, default 0: arithmetic right shift applied to the accumulator before output.
- `clk`, input, 1: single clock, all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset; it is sampled only on `clk` rising edges.
- `x_in`, input, `DATA_W`: signed input sample, sampled every rising edge.
- `y_out`, output, `DATA_W`: signed filtered sample, registered.

## Operation
- **Coefficients:** h[0..7] = {1, 2, 3, 4, 4, 3, 2, 1}. They are fixed constants, not runtime-loadable.
- **Delay line:** d[0..TAPS-2] holds the previous samples. Each edge: d[0] ← x_in, d[k] ← d[k-1].
- **Output equation:** y(n) = (h0·x_in + Σ_{k=1..TAPS-1} h[k]·d[k-1]) >>> SHIFT.
- **Arithmetic:**
  - Products are full precision (`DATA_W`+`COEF_W` bits).
  - The accumulator is `DATA_W`+`COEF_W`+ceil(log2 TAPS) bits (51 by default), so no intermediate overflow is possible.
  - The shift is arithmetic, so the sign is preserved.
- **Output narrowing:** the accumulator is reduced to `DATA_W` bits per the Configuration section.
- **Reset (`reset`==0 at a rising edge):**
  - All delay-line registers go to 0 and `y_out` goes to 0.
  - `x_in` is ignored for that edge.
- **Reset mid-stream:** all history is discarded. After release, the response is identical to a fresh start.
- **No enable, no valid:** every edge with `reset`==1 is a sample.

## Timing
- **Latency:** 1 cycle. `x_in` sampled at edge n contributes h0·x_in to `y_out` immediately after edge n.
- **Impulse span:** an impulse affects `y_out` for exactly `TAPS` consecutive cycles.
- **Throughput:** 1 sample/cycle.
- **Combinational paths:** none from `x_in` to `y_out`.
- **Reset value:** `y_out` = 0 from the first edge with `reset`==0 until the first edge after release.
- **First output after release:** the first edge with `reset`==1 produces h0·x_in (history = 0).

## Configuration
- **Macro `FIR_SATURATE_EN`:**
  - Defined: the shifted accumulator is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1] before loading `y_out`.
  - Undefined: the low `DATA_W` bits are taken, giving two's-complement wrap.
- In-range results are identical in both builds.

## Structure
- **Package `fir_pkg`:** holds `DATA_W`/`COEF_W`/`TAPS` defaults, the coefficient constant array, the derived accumulator width, and the typedefs `sample_t`, `coef_t`, `acc_t`.
- **Sub-module `fir_out_sat`:** one natural sub-module. It is purely combinational: shift, then saturate or wrap per `FIR_SATURATE_EN`, narrowing `acc_t` to `sample_t`.
- **Top level:** holds the delay line, the multiply-accumulate, and the output register.

## Test plan
- **Reset held:** reset low for 10 cycles with x_in=100 → `y_out`=0 throughout. Release with x_in=0 → `y_out` stays 0.
- **Impulse:** x_in=100 for one cycle then 0 → `y_out` = 100, 200, 300, 400, 400, 300, 200, 100, then 0 thereafter.
- **Ramp:** x_in = 100, 200, 300, 400, 500, then 0 → `y_out` = 100, 400, 1000, 2000, 3400, 4500, 5100, …, settling to 0 after 12 outputs.
- **DC:** x_in held at −1000 → `y_out` ramps to −20000 by the 8th output and holds.
- **Overflow:** x_in held at 0x7FFFFFFF.
  - With `FIR_SATURATE_EN`: `y_out` reaches 0x7FFFFFFF and holds.
  - Without it: `y_out` equals the low 32 bits of 20·(2^31−1) (0xFFFFFFEC).
- **Reset mid-stream:** during the ramp, reset low for one edge → `y_out`=0 next cycle. After release, the impulse response matches a fresh start with no residue.
